jtag_ir_decode: RTL and testbench

//  JTAG instruction register and decoder. Shifts an opcode in from TDI while the TAP is in

---
 rtl/jtag_ir_decode_pkg.sv | 21 ++
 rtl/jtag_ir_decode_if.sv | 26 ++
 rtl/jtag_ir_opdec.sv | 34 +++
 rtl/jtag_ir_decode.sv | 59 +++++
 tb/tb_jtag_ir_decode.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/jtag_ir_decode_pkg.sv
// Shared opcode, DR-select and capture constants for the JTAG instruction register.
// Opcodes are given as integers and are zero-extended to the configured IR length.
package jtag_ir_decode_pkg;

  localparam int unsigned OP_EXTEST = 0;
  localparam int unsigned OP_IDCODE = 1;
  localparam int unsigned OP_SAMPLE = 2;
  localparam int unsigned OP_BIST   = 3;

  // The bypass opcode is all ones at any IR length. Any opcode that is not
  // listed above also decodes as bypass.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [1:0] {
    SEL_BP   = 2'b00,
    SEL_ID   = 2'b01,
    SEL_BS   = 2'b10,
    SEL_BIST = 2'b11
  } dr_sel_e;

endpackage

// File: rtl/jtag_ir_decode_if.sv
// Connection between the TAP controller (strobes and TDI) and the instruction register.
// The IR drives the DR-select, mode and debug outputs back over the same bundle.
interface jtag_ir_decode_if #(
  parameter int IR_WIDTH = 4
);
  logic                TLR;
  logic                Capture_IR;
  logic                Shift_IR;
  logic                Update_IR;
  logic                TDI;
  logic                IR_TDO;
  logic [1:0]          DR_Sel;
  logic                Extest_Mode;
  logic                Bist_Start;
  logic [IR_WIDTH-1:0] Active_IR;

  modport master (
    output TLR, Capture_IR, Shift_IR, Update_IR, TDI,
    input  IR_TDO, DR_Sel, Extest_Mode, Bist_Start, Active_IR
  );

  modport slave (
    input  TLR, Capture_IR, Shift_IR, Update_IR, TDI,
    output IR_TDO, DR_Sel, Extest_Mode, Bist_Start, Active_IR
  );
endinterface

// File: rtl/jtag_ir_opdec.sv
// Pure combinational opcode decoder that maps an opcode to the DR-mux select and the EXTEST mode.
// Unknown opcodes select the bypass register.
module jtag_ir_opdec
  import jtag_ir_decode_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input  logic [IR_WIDTH-1:0] opcode,
  output dr_sel_e             dr_sel,
  output logic                extest_mode
);

  localparam logic [IR_WIDTH-1:0] EXTEST_CODE = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] SAMPLE_CODE = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] BIST_CODE   = IR_WIDTH'(OP_BIST);

  always_comb begin
    // NOTE: default every output before branching so that no path leaves an output unassigned and no latch is inferred.
    dr_sel      = SEL_BP;
    extest_mode = 1'b0;
    if (opcode == EXTEST_CODE) begin
      dr_sel      = SEL_BS;
      extest_mode = 1'b1;
    end else if (opcode == SAMPLE_CODE) begin
      dr_sel = SEL_BS;
    end else if (opcode == IDCODE_CODE) begin
      dr_sel = SEL_ID;
    end else if (opcode == BIST_CODE) begin
      dr_sel = SEL_BIST;
    end
  end

endmodule

// File: rtl/jtag_ir_decode.sv
// JTAG instruction register: serial shift register, active (shadow) opcode, and a BIST start pulse.
// The active opcode is decoded into the DR-mux select and the EXTEST mode.
module jtag_ir_decode
  import jtag_ir_decode_pkg::*;
#(
  parameter int IR_WIDTH = 4
) (
  input logic             TCK,
  input logic             TRST_n,
  jtag_ir_decode_if.slave bus
);

  localparam logic [IR_WIDTH-1:0] CAPTURE_VAL = IR_WIDTH'(IR_CAPTURE);
  localparam logic [IR_WIDTH-1:0] IDCODE_VAL  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] BIST_VAL    = IR_WIDTH'(OP_BIST);

  logic [IR_WIDTH-1:0] shift_reg;
  logic [IR_WIDTH-1:0] active_ir;
  logic                bist_start;
  dr_sel_e             dr_sel;
  logic                extest_mode;

  // Strobe priority is TLR > Update_IR > Capture_IR > Shift_IR. Because of
  // this, the active opcode only changes on TLR or Update_IR, and DR_Sel
  // stays stable while a scan is in progress.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      shift_reg  <= CAPTURE_VAL;
      active_ir  <= IDCODE_VAL;
      bist_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      bist_start <= 1'b0;
      if (bus.TLR) begin
        active_ir <= IDCODE_VAL;
      end else if (bus.Update_IR) begin
        active_ir  <= shift_reg;
        bist_start <= (shift_reg == BIST_VAL);
      end else if (bus.Capture_IR) begin
        shift_reg <= CAPTURE_VAL;
      end else if (bus.Shift_IR) begin
        shift_reg <= {bus.TDI, shift_reg[IR_WIDTH-1:1]};
      end
    end
  end

  jtag_ir_opdec #(.IR_WIDTH(IR_WIDTH)) u_opdec (
    .opcode      (active_ir),
    .dr_sel      (dr_sel),
    .extest_mode (extest_mode)
  );

  assign bus.IR_TDO      = shift_reg[0];
  assign bus.DR_Sel      = dr_sel;
  assign bus.Extest_Mode = extest_mode;
  assign bus.Bist_Start  = bist_start;
  assign bus.Active_IR   = active_ir;

endmodule

// File: tb/tb_jtag_ir_decode.sv
// Scoreboard bench for jtag_ir_decode. A bench-side model pushes the expected outputs for each step,
// and each entry is popped and compared after the corresponding TCK edge.
module tb_jtag_ir_decode;

  typedef struct {
    string      tag;
    logic       tdo;
    logic [1:0] sel;
    logic       ext;
    logic       bist;
    logic [3:0] air;
  } exp_t;

  logic TCK;
  logic TRST_n;
  int   n_checks;
  int   n_pass;

  exp_t sb[$];

  logic [3:0] m_sr;
  logic [3:0] m_air;
  logic       m_bist;

  jtag_ir_decode_if #(.IR_WIDTH(4)) bus ();

  jtag_ir_decode #(.IR_WIDTH(4)) dut (
    .TCK    (TCK),
    .TRST_n (TRST_n),
    .bus    (bus)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic logic [1:0] ref_sel(input logic [3:0] op);
    case (op)
      4'b0000: return 2'b10;
      4'b0010: return 2'b10;
      4'b0001: return 2'b01;
      4'b0011: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag  = tag;
    e.tdo  = m_sr[0];
    e.sel  = ref_sel(m_air);
    e.ext  = (m_air == 4'b0000);
    e.bist = m_bist;
    e.air  = m_air;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".tdo"},  32'(bus.IR_TDO),      32'(e.tdo));
    check({e.tag, ".sel"},  32'(bus.DR_Sel),      32'(e.sel));
    check({e.tag, ".ext"},  32'(bus.Extest_Mode), 32'(e.ext));
    check({e.tag, ".bist"}, 32'(bus.Bist_Start),  32'(e.bist));
    check({e.tag, ".air"},  32'(bus.Active_IR),   32'(e.air));
  endtask

  // Drive one set of strobes, advance the model, and compare after the edge.
  task automatic step(input logic tlr, input logic cap, input logic sh,
                      input logic upd, input logic tdi, input string tag);
    bus.TLR        = tlr;
    bus.Capture_IR = cap;
    bus.Shift_IR   = sh;
    bus.Update_IR  = upd;
    bus.TDI        = tdi;
    if (tlr) begin
      m_air  = 4'b0001;
      m_bist = 1'b0;
    end else if (upd) begin
      m_bist = (m_sr == 4'b0011);
      m_air  = m_sr;
    end else begin
      m_bist = 1'b0;
      if (cap)     m_sr = 4'b0001;
      else if (sh) m_sr = {tdi, m_sr[3:1]};
    end
    push_expect(tag);
    @(posedge TCK);
    #1;
    compare_out();
  endtask

  task automatic apply_reset(input string tag);
    TRST_n = 1'b0;
    m_sr   = 4'b0001;
    m_air  = 4'b0001;
    m_bist = 1'b0;
    push_expect(tag);
    #1;
    compare_out();
  endtask

  task automatic load_ir(input logic [3:0] val, input string tag);
    step(0, 1, 0, 0, 0, {tag, ".cap"});
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, val[i], {tag, ".sh"});
    step(0, 0, 0, 1, 0, {tag, ".upd"});
    step(0, 0, 0, 0, 0, {tag, ".idle"});
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    TRST_n         = 1'b1;
    bus.TLR        = 1'b0;
    bus.Capture_IR = 1'b0;
    bus.Shift_IR   = 1'b0;
    bus.Update_IR  = 1'b0;
    bus.TDI        = 1'b0;

    // Asynchronous reset before the first TCK edge.
    #2;
    apply_reset("reset_async");
    @(posedge TCK);
    #1;
    TRST_n = 1'b1;
    step(0, 0, 0, 0, 0, "reset_hold");

    // Capture, then shift in ones and load BYPASS.
    load_ir(4'b1111, "bypass");
    load_ir(4'b0000, "extest");
    load_ir(4'b0010, "sample");

    // Load BIST twice, then IDCODE, which must not produce a pulse.
    load_ir(4'b0011, "bist1");
    load_ir(4'b0011, "bist2");
    step(0, 0, 0, 1, 0, "bist_back2back");
    step(0, 0, 0, 0, 0, "bist_back2back_idle");
    load_ir(4'b0001, "idcode");

    // Unknown opcode, then Test-Logic-Reset.
    load_ir(4'b0101, "unknown");
    step(1, 0, 0, 0, 0, "tlr");
    step(0, 0, 0, 0, 0, "tlr_idle");

    // Simultaneous strobes resolve by priority.
    load_ir(4'b0000, "pre_prio");
    step(0, 1, 1, 0, 1, "cap_over_shift");
    step(0, 0, 1, 0, 1, "shift_a");
    step(0, 0, 1, 0, 1, "shift_b");
    step(1, 0, 0, 1, 0, "tlr_over_upd");
    step(0, 1, 0, 1, 0, "upd_over_cap");
    step(0, 0, 0, 0, 0, "prio_idle");

    // Reset in the middle of a shift discards the partial contents.
    load_ir(4'b0010, "pre_trst");
    step(0, 1, 0, 0, 0, "trst.cap");
    step(0, 0, 1, 0, 1, "trst.sh0");
    step(0, 0, 1, 0, 0, "trst.sh1");
    apply_reset("trst_mid_shift");
    @(posedge TCK);
    #1;
    TRST_n = 1'b1;
    step(0, 0, 0, 0, 0, "trst_release");
    load_ir(4'b1010, "post_trst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
